// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
//   Sequential radix-2 Booth multiplier for signed two's-complement operands.
//   One shared WIDTH+1-bit ripple adder, built from booth_fa cells, performs
//   one partial-product step per clock. The result is ready WIDTH+1 cycles
//   after an accepted start.
//
//   Ports
//     clk           in   rising-edge clock
//     rst_n         in   asynchronous active-low reset
//     start         in   multiply request, sampled when busy=0
//     multiplicand  in   signed M, captured on the accepting edge
//     multiplier    in   signed Q, captured on the accepting edge
//     busy          out  high while iterating (RUN)
//     done          out  one-cycle pulse, product valid from this cycle
//     product       out  signed M*Q, held until the next completion
//     state_dbg     out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
//   Handshake: a request is accepted on a rising clk edge where start=1 and
//   the block is in IDLE or DONE (busy=0). start is ignored while busy=1.
//   done rises for exactly one cycle when product is updated; no
//   acknowledge is needed and product stays stable until the next done.

module booth_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module booth_seq_multiplier #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   a_reg;   // one guard bit so A - (-2^(W-1)) cannot overflow
  logic [WIDTH-1:0] q_reg;
  logic             qm1;
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic             sub;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   a_next;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;

  // {Q[0],Qm1} = 10 subtracts M (invert and carry in 1), 01 adds M.
  assign sub      = q_reg[0] & ~qm1;
  assign add_b    = sub ? ~{m_reg[WIDTH-1], m_reg} : {m_reg[WIDTH-1], m_reg};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    booth_fa u_fa (
      .a    (a_reg[i]),
      .b    (add_b[i]),
      .cin  (carry[i]),
      .sum  (add_sum[i]),
      .cout (carry[i+1])
    );
  end

  // The carry out of the sign position carries no information in two's
  // complement, so the top cell only forms the sum.
  assign add_sum[WIDTH] = a_reg[WIDTH] ^ add_b[WIDTH] ^ carry[WIDTH];

  // 00 / 11 leave A unchanged; the adder result is discarded.
  assign a_next = (q_reg[0] ^ qm1) ? add_sum : a_reg;

  // Arithmetic right shift of {A_next, Q, Qm1}.
  assign a_sh = {a_next[WIDTH], a_next[WIDTH:1]};
  assign q_sh = {a_next[0], q_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      m_reg <= multiplicand;
      q_reg <= multiplier;
      a_reg <= '0;
      qm1   <= 1'b0;
      cnt   <= CNT_W'(WIDTH - 1);
    end else if (state == RUN) begin
      a_reg <= a_sh;
      q_reg <= q_sh;
      qm1   <= q_reg[0];
      if (cnt == '0) product <= {a_sh[WIDTH-1:0], q_sh};
      else           cnt     <= cnt - CNT_W'(1);
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier
//   Directed bench for booth_seq_multiplier (WIDTH=5): reset state, basic
//   latency, signed corner products, start-while-busy, start during done,
//   reset mid-run and an exhaustive operand sweep.

module tb_booth_seq_multiplier;

  localparam int W = 5;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  int n_cmp;
  int n_fail;

  booth_seq_multiplier #(.WIDTH(W), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issue one start, then wait (bounded) for done.
  // Returns in the done cycle; lat = cycle index of done (0 = timeout).
  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q,
                          output logic [2*W-1:0] p, output int lat,
                          output int busy_cycles);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    p = '0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        p   = product;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b product=%h state=%0d required 0/0/000/0",
               busy, done, product, state_dbg);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p;
    int lat, bc;
    run_mult(5'd7, 5'd3, p, lat, bc);
    n_cmp++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL basic_latency done_cycle=%0d required 6", lat);
    end
    n_cmp++;
    if (bc !== 5) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got=%0d required 5", bc);
    end
    n_cmp++;
    if (p !== 10'h015) begin
      n_fail++;
      $display("FAIL basic_product got=%h required 015", p);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_in_done got=%b required 0", busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || product !== 10'h015) begin
      n_fail++;
      $display("FAIL basic_after_done done=%b product=%h required 0/015", done, product);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   tm[7];
    logic [W-1:0]   tq[7];
    logic [2*W-1:0] tp[7];
    logic [2*W-1:0] p;
    int lat, bc;
    tm[0] = 5'h10; tq[0] = 5'h10; tp[0] = 10'h100; // -16 * -16
    tm[1] = 5'h10; tq[1] = 5'h0F; tp[1] = 10'h310; // -16 *  15
    tm[2] = 5'h0F; tq[2] = 5'h10; tp[2] = 10'h310; //  15 * -16
    tm[3] = 5'h1F; tq[3] = 5'h1F; tp[3] = 10'h001; //  -1 *  -1
    tm[4] = 5'h00; tq[4] = 5'h17; tp[4] = 10'h000; //   0 *  -9
    tm[5] = 5'h05; tq[5] = 5'h1A; tp[5] = 10'h3E2; //   5 *  -6
    tm[6] = 5'h0F; tq[6] = 5'h0F; tp[6] = 10'h0E1; //  15 *  15
    for (int k = 0; k < 7; k++) begin
      run_mult(tm[k], tq[k], p, lat, bc);
      n_cmp++;
      if (lat !== 6 || p !== tp[k]) begin
        n_fail++;
        $display("FAIL corner_%0d m=%h q=%h product=%h done_cycle=%0d required %h at 6",
                 k, tm[k], tq[k], p, lat, tp[k]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    int first_done;
    multiplicand = 5'd7;
    multiplier   = 5'd3;
    start = 1'b1;
    tick();            // accepted, now cycle 1
    start = 1'b0;
    tick();            // cycle 2
    multiplicand = 5'd9;
    multiplier   = 5'd9;
    start = 1'b1;
    tick();            // edge 2 ignored, now cycle 3
    start = 1'b0;
    pulses = 0;
    first_done = 0;
    for (int i = 3; i <= 16; i++) begin
      if (done) begin
        pulses++;
        if (first_done == 0) begin
          first_done = i;
          n_cmp++;
          if (product !== 10'h015) begin
            n_fail++;
            $display("FAIL ignore_product got=%h required 015", product);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (pulses !== 1 || first_done !== 6) begin
      n_fail++;
      $display("FAIL ignore_pulses count=%0d first=%0d required 1 at 6", pulses, first_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p;
    int lat, bc;
    int nxt;
    run_mult(5'd7, 5'd3, p, lat, bc);
    n_cmp++;
    if (lat !== 6 || p !== 10'h015) begin
      n_fail++;
      $display("FAIL b2b_first product=%h done_cycle=%0d required 015 at 6", p, lat);
    end
    multiplicand = 5'd3;
    multiplier   = 5'd4;
    start = 1'b1;
    tick();            // accepted from DONE
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || product !== 10'h015) begin
      n_fail++;
      $display("FAIL b2b_no_gap busy=%b product=%h required 1/015", busy, product);
    end
    nxt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        nxt = i;
        break;
      end
      if (product !== 10'h015) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b2b_hold cycle=%0d product=%h required 015", i, product);
      end
      tick();
    end
    n_cmp++;
    if (nxt !== 6 || product !== 10'h00C) begin
      n_fail++;
      $display("FAIL b2b_second product=%h done_cycle=%0d required 00C at 6", product, nxt);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] p;
    int lat, bc;
    int pulses;
    multiplicand = 5'd7;
    multiplier   = 5'd3;
    start = 1'b1;
    tick();            // cycle 1
    start = 1'b0;
    tick();            // cycle 2
    tick();            // cycle 3
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_immediate busy=%b done=%b product=%h state=%0d required 0/0/000/0",
               busy, done, product, state_dbg);
    end
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet active_cycles=%0d required 0", pulses);
    end
    run_mult(5'h1D, 5'h07, p, lat, bc);   // -3 * 7
    n_cmp++;
    if (lat !== 6 || p !== 10'h3EB) begin
      n_fail++;
      $display("FAIL abort_restart product=%h done_cycle=%0d required 3EB at 6", p, lat);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [W-1:0]          m, q;
    logic signed [W-1:0]   ms, qs;
    logic signed [2*W-1:0] e;
    logic [2*W-1:0]        p;
    int lat, bc, off, idx;
    off = $urandom_range(0, 1023);
    for (int i = 0; i < 1024; i++) begin
      idx = (i + off) % 1024;
      m = W'(idx / 32);
      q = W'(idx % 32);
      ms = m;
      qs = q;
      e = ms * qs;
      run_mult(m, q, p, lat, bc);
      n_cmp++;
      if (lat !== 6 || p !== e) begin
        n_fail++;
        $display("FAIL sweep m=%h q=%h product=%h done_cycle=%0d required %h at 6",
                 m, q, p, lat, e);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
